// File: rtl/execute_stage_pkg.sv
// Pipeline definitions shared by the execute stage: widths, ALU control codes,
// the EX/MEM register payload and a helper that flags undefined ALU codes.
package execute_stage_pkg;

    localparam int unsigned NB_DATA      = 32;
    localparam int unsigned NB_ALU_CTRLI = 4;
    localparam int unsigned NB_REG_ADDR  = 5;
    localparam int unsigned NB_SHAMT     = 5;

    // ALU control codes as produced by the ALU control decoder.
    typedef enum logic [NB_ALU_CTRLI-1:0] {
        ALU_SLL   = 4'h0,
        ALU_SRL   = 4'h1,
        ALU_SRA   = 4'h2,
        ALU_ADD   = 4'h3,
        ALU_SUB   = 4'h4,
        ALU_AND   = 4'h5,
        ALU_OR    = 4'h6,
        ALU_XOR   = 4'h7,
        ALU_NOR   = 4'h8,
        ALU_SLT   = 4'h9,
        ALU_RSV_A = 4'hA,
        ALU_RSV_B = 4'hB,
        ALU_RSV_C = 4'hC,
        ALU_LUI   = 4'hD,
        ALU_BEQ   = 4'hE,
        ALU_BNE   = 4'hF
    } alu_ctrl_e;

    // EX/MEM pipeline register contents.
    typedef struct packed {
        logic [NB_DATA-1:0]     result;
        logic [NB_REG_ADDR-1:0] rd_addr;
        logic                   reg_write;
        logic                   valid;
        logic                   branch_taken;
        logic [NB_DATA-1:0]     branch_target;
        logic                   zero;
    } ex_mem_t;

    // Codes 0xA..0xC have no operation behind them.
    function automatic logic alu_code_defined(input logic [NB_ALU_CTRLI-1:0] code);
        return !((code == ALU_RSV_A) || (code == ALU_RSV_B) || (code == ALU_RSV_C));
    endfunction

endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational ALU of the execute stage.
// Ports: code (ALU control), a/b operands, shamt + shift_var select the shift
// amount; result, zero (result == 0) and branch_cond (BEQ/BNE decision).
module alu_core
    import execute_stage_pkg::*;
(
    input  logic [NB_ALU_CTRLI-1:0] code,
    input  logic [NB_DATA-1:0]      a,
    input  logic [NB_DATA-1:0]      b,
    input  logic [NB_SHAMT-1:0]     shamt,
    input  logic                    shift_var,
    output logic [NB_DATA-1:0]      result,
    output logic                    zero,
    output logic                    branch_cond
);

    logic [NB_SHAMT-1:0] amt;
    logic [NB_DATA-1:0]  diff;

    // Variable shifts take the amount from rs, fixed shifts from the shamt field.
    assign amt  = shift_var ? a[NB_SHAMT-1:0] : shamt;
    assign diff = a - b;

    always_comb begin
        result      = '0;
        branch_cond = 1'b0;
        case (code)
            ALU_SLL: result = b << amt;
            ALU_SRL: result = b >> amt;
            ALU_SRA: result = $unsigned($signed(b) >>> amt);
            ALU_ADD: result = a + b;
            ALU_SUB: result = diff;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = NB_DATA'($signed(a) < $signed(b));
            ALU_LUI: result = {b[NB_DATA/2-1:0], (NB_DATA/2)'(0)};
            ALU_BEQ: begin
                result      = diff;
                branch_cond = (diff == '0);
            end
            ALU_BNE: begin
                result      = diff;
                branch_cond = (diff != '0);
            end
            default: begin
                result      = '0;
                branch_cond = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: ALU, branch target adder and the EX/MEM register with
// valid/stall/flush handling. One cycle from accepted inputs to outputs.
// Inputs: clock, sync active-high reset, valid/stall/flush controls, ALU code,
// operands, shift controls, immediate, PC+4, destination and write enable.
// Outputs: registered result, destination, write enable, valid, branch
// decision/target and zero flag.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic [NB_ALU_CTRLI-1:0] i_alu_control_input,
    input  logic [NB_DATA-1:0]      i_data_a,
    input  logic [NB_DATA-1:0]      i_data_b,
    input  logic [NB_SHAMT-1:0]     i_shamt,
    input  logic                    i_shift_var,
    input  logic [NB_DATA-1:0]      i_imm_ext,
    input  logic [NB_DATA-1:0]      i_pc_plus4,
    input  logic [NB_REG_ADDR-1:0]  i_rd_addr,
    input  logic                    i_reg_write,
    output logic [NB_DATA-1:0]      o_result,
    output logic [NB_REG_ADDR-1:0]  o_rd_addr,
    output logic                    o_reg_write,
    output logic                    o_valid,
    output logic                    o_branch_taken,
    output logic [NB_DATA-1:0]      o_branch_target,
    output logic                    o_zero
);

    logic [NB_DATA-1:0] alu_result;
    logic               alu_zero;
    logic               alu_branch_cond;
    ex_mem_t            ex_mem;
    ex_mem_t            ex_mem_next;

    alu_core u_alu_core (
        .code        (i_alu_control_input),
        .a           (i_data_a),
        .b           (i_data_b),
        .shamt       (i_shamt),
        .shift_var   (i_shift_var),
        .result      (alu_result),
        .zero        (alu_zero),
        .branch_cond (alu_branch_cond)
    );

    // Value captured on a normal (non-stalled, non-flushed) edge.
    always_comb begin
        ex_mem_next               = '0;
        ex_mem_next.result        = alu_result;
        ex_mem_next.rd_addr       = i_rd_addr;
        ex_mem_next.reg_write     = i_valid && i_reg_write && alu_code_defined(i_alu_control_input);
        ex_mem_next.valid         = i_valid;
        ex_mem_next.branch_taken  = i_valid && alu_branch_cond;
        ex_mem_next.branch_target = i_pc_plus4 + (i_imm_ext << 2);
        ex_mem_next.zero          = alu_zero;
    end

    // EX/MEM register: reset > flush > stall > capture; flush keeps data fields.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_mem <= '0;
        end else if (i_flush) begin
            ex_mem.valid        <= 1'b0;
            ex_mem.reg_write    <= 1'b0;
            ex_mem.branch_taken <= 1'b0;
        end else if (!i_stall) begin
            ex_mem <= ex_mem_next;
        end
    end

    assign o_result        = ex_mem.result;
    assign o_rd_addr       = ex_mem.rd_addr;
    assign o_reg_write     = ex_mem.reg_write;
    assign o_valid         = ex_mem.valid;
    assign o_branch_taken  = ex_mem.branch_taken;
    assign o_branch_target = ex_mem.branch_target;
    assign o_zero          = ex_mem.zero;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic [3:0]  i_alu_control_input = '0;
    logic [31:0] i_data_a = '0;
    logic [31:0] i_data_b = '0;
    logic [4:0]  i_shamt = '0;
    logic        i_shift_var = 1'b0;
    logic [31:0] i_imm_ext = '0;
    logic [31:0] i_pc_plus4 = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_reg_write = 1'b0;

    logic [31:0] o_result;
    logic [4:0]  o_rd_addr;
    logic        o_reg_write;
    logic        o_valid;
    logic        o_branch_taken;
    logic [31:0] o_branch_target;
    logic        o_zero;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .i_clk               (clk),
        .i_reset             (i_reset),
        .i_valid             (i_valid),
        .i_stall             (i_stall),
        .i_flush             (i_flush),
        .i_alu_control_input (i_alu_control_input),
        .i_data_a            (i_data_a),
        .i_data_b            (i_data_b),
        .i_shamt             (i_shamt),
        .i_shift_var         (i_shift_var),
        .i_imm_ext           (i_imm_ext),
        .i_pc_plus4          (i_pc_plus4),
        .i_rd_addr           (i_rd_addr),
        .i_reg_write         (i_reg_write),
        .o_result            (o_result),
        .o_rd_addr           (o_rd_addr),
        .o_reg_write         (o_reg_write),
        .o_valid             (o_valid),
        .o_branch_taken      (o_branch_taken),
        .o_branch_target     (o_branch_target),
        .o_zero              (o_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural ALU: shifts expressed as multiply/divide by powers of two.
    function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh,
                                              input logic sv);
        logic [4:0]  n;
        logic [31:0] pw;
        logic [63:0] prod;
        n    = sv ? a[4:0] : sh;
        pw   = 32'd1 << n;
        prod = 64'(b) * 64'(pw);
        case (c)
            4'h0: return prod[31:0];
            4'h1: return b / pw;
            4'h2: return b[31] ? ~((~b) / pw) : (b / pw);
            4'h3: return a + b;
            4'h4: return a - b;
            4'h5: return a & b;
            4'h6: return a | b;
            4'h7: return a ^ b;
            4'h8: return ~(a | b);
            4'h9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hD: return 32'(b[15:0]) * 32'd65536;
            4'hE: return a - b;
            4'hF: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // Model of the EX/MEM register contents.
    bit          m_known = 1'b0;
    bit          m_dc    = 1'b0;
    logic [31:0] m_result, m_target;
    logic [4:0]  m_rd;
    logic        m_rw, m_valid, m_bt, m_zero;

    always @(posedge clk) begin
        if (i_reset) begin
            m_known  <= 1'b1;
            m_dc     <= 1'b0;
            m_result <= '0;
            m_target <= '0;
            m_rd     <= '0;
            m_rw     <= 1'b0;
            m_valid  <= 1'b0;
            m_bt     <= 1'b0;
            m_zero   <= 1'b0;
        end else if (i_flush) begin
            m_valid <= 1'b0;
            m_rw    <= 1'b0;
            m_bt    <= 1'b0;
        end else if (!i_stall) begin
            m_valid  <= i_valid;
            m_dc     <= !i_valid;
            m_rw     <= i_valid && i_reg_write &&
                        !(i_alu_control_input >= 4'hA && i_alu_control_input <= 4'hC);
            m_bt     <= i_valid && ((i_alu_control_input == 4'hE && i_data_a == i_data_b) ||
                                    (i_alu_control_input == 4'hF && i_data_a != i_data_b));
            m_result <= model_alu(i_alu_control_input, i_data_a, i_data_b, i_shamt, i_shift_var);
            m_zero   <= model_alu(i_alu_control_input, i_data_a, i_data_b, i_shamt, i_shift_var) == 32'd0;
            m_target <= i_pc_plus4 + i_imm_ext * 32'd4;
            m_rd     <= i_rd_addr;
        end
    end

    // Per-cycle compare against the model; data fields skipped when don't-care.
    always @(negedge clk) begin
        if (m_known) begin
            chk("m_valid", 32'(o_valid), 32'(m_valid));
            chk("m_reg_write", 32'(o_reg_write), 32'(m_rw));
            chk("m_branch_taken", 32'(o_branch_taken), 32'(m_bt));
            if (!m_dc) begin
                chk("m_result", o_result, m_result);
                chk("m_rd_addr", 32'(o_rd_addr), 32'(m_rd));
                chk("m_target", o_branch_target, m_target);
                chk("m_zero", 32'(o_zero), 32'(m_zero));
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic sv, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic v, input logic st, input logic fl, input logic rs);
        i_alu_control_input = c;
        i_data_a            = a;
        i_data_b            = b;
        i_shamt             = sh;
        i_shift_var         = sv;
        i_imm_ext           = imm;
        i_pc_plus4          = pc;
        i_rd_addr           = rd;
        i_reg_write         = rw;
        i_valid             = v;
        i_stall             = st;
        i_flush             = fl;
        i_reset             = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic alu_vec(input string name, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic sv,
                           input logic [31:0] exp);
        drive(c, a, b, sh, sv, 32'h4, 32'h40, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk(name, o_result, exp);
    endtask

    initial begin
        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            drive(4'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                  $urandom, 5'($urandom), 1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b1);
            step();
        end
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_target", o_branch_target, 32'd0);
        chk("rst_flags", {27'd0, o_reg_write, o_branch_taken, o_zero, 2'b00}, 32'd0);
        chk("rst_rd", 32'(o_rd_addr), 32'd0);

        // First capture after reset: ADD wrap to zero.
        drive(4'h3, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1,
              1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_wrap_result", o_result, 32'd0);
        chk("add_wrap_zero", 32'(o_zero), 32'd1);
        chk("add_wrap_valid", 32'(o_valid), 32'd1);
        chk("add_wrap_rw", 32'(o_reg_write), 32'd1);

        alu_vec("sub", 4'h4, 32'd5, 32'd7, 5'd0, 1'b0, 32'hFFFF_FFFE);
        alu_vec("slt", 4'h9, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 32'd1);
        alu_vec("sra", 4'h2, 32'h0, 32'h8000_0000, 5'd4, 1'b0, 32'hF800_0000);
        alu_vec("srl", 4'h1, 32'h0, 32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000);
        alu_vec("sllv", 4'h0, 32'h21, 32'h1, 5'd9, 1'b1, 32'h0000_0002);
        alu_vec("lui", 4'hD, 32'h0, 32'h1234, 5'd0, 1'b0, 32'h1234_0000);
        alu_vec("nor", 4'h8, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 1'b0, 32'h0F0F_F0F0);

        // Branches.
        drive(4'hE, 32'h10, 32'h10, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h100, 5'd0, 1'b0,
              1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("beq_taken", 32'(o_branch_taken), 32'd1);
        chk("beq_target", o_branch_target, 32'h0000_00FC);
        drive(4'hF, 32'h10, 32'h10, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h100, 5'd0, 1'b0,
              1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("bne_taken", 32'(o_branch_taken), 32'd0);

        // Undefined code: result 0, write suppressed, still valid.
        drive(4'hB, 32'h55, 32'h66, 5'd0, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1,
              1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("undef_result", o_result, 32'd0);
        chk("undef_rw", 32'(o_reg_write), 32'd0);
        chk("undef_valid", 32'(o_valid), 32'd1);

        // Capture ADD = 9, then stall three cycles with new inputs.
        drive(4'h3, 32'd4, 32'd5, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1,
              1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("add9_result", o_result, 32'd9);
        for (int i = 0; i < 3; i++) begin
            drive(4'h4, 32'd100 + 32'(i), 32'd1, 5'd0, 1'b0, 32'h0, 32'h0, 5'd12, 1'b1,
                  1'b1, 1'b1, 1'b0, 1'b0);
            step();
            chk("stall_result", o_result, 32'd9);
            chk("stall_valid", 32'(o_valid), 32'd1);
        end
        drive(4'h4, 32'd100, 32'd1, 5'd0, 1'b0, 32'h0, 32'h0, 5'd12, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_rw", 32'(o_reg_write), 32'd0);
        chk("flush_result", o_result, 32'd9);

        // Reset mid-stall clears; capture resumes only once the stall drops.
        drive(4'h6, 32'h1, 32'h2, 5'd0, 1'b0, 32'h0, 32'h0, 5'd1, 1'b1,
              1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("rst_stall_result", o_result, 32'd0);
        drive(4'h6, 32'h1, 32'h2, 5'd0, 1'b0, 32'h0, 32'h0, 5'd1, 1'b1,
              1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("post_rst_stall_valid", 32'(o_valid), 32'd0);
        drive(4'h6, 32'h1, 32'h2, 5'd0, 1'b0, 32'h0, 32'h0, 5'd1, 1'b1,
              1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("post_rst_capture", o_result, 32'd3);
        chk("post_rst_valid", 32'(o_valid), 32'd1);

        // Bubble capture: control flags drop.
        drive(4'hE, 32'h7, 32'h7, 5'd0, 1'b0, 32'h0, 32'h0, 5'd1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("bubble_valid", 32'(o_valid), 32'd0);
        chk("bubble_bt", 32'(o_branch_taken), 32'd0);

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            drive(4'($urandom), ra, rb, 5'($urandom), 1'($urandom), $urandom, $urandom,
                  5'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 24) == 0));
            step();
        end

        drive(4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
